// File: rtl/fmdll_freq_ctrl.sv
// FMDLL frequency compare and delay-code control, CLK_exit domain.
// Counts synchronized N-wrap events per M window and steps the delay code toward one wrap per window.
module fmdll_freq_ctrl #(
   parameter int CODE_W    = 6,
   parameter int CODE_INIT = 32,
   parameter int LOCK_N    = 4,
   parameter int UNLOCK_N  = 2,
   parameter int EVW       = 3
) (
   input  logic              CLK_exit,
   input  logic              rst_n,
   input  logic              en,
   input  logic [1:0]        M,
   input  logic [1:0]        M_counter,
   input  logic              n_wrap_tgl,
   output logic [CODE_W-1:0] code,
   output logic              up,
   output logic              dn,
   output logic              locked
);
   localparam int RUN_MAX = (LOCK_N > UNLOCK_N) ? LOCK_N : UNLOCK_N;
   localparam int RUN_W   = $clog2(RUN_MAX + 1);
   localparam logic [CODE_W-1:0] CODE_MAX   = '1;
   localparam logic [CODE_W-1:0] CODE_RST   = CODE_W'(CODE_INIT);
   localparam logic [EVW-1:0]    EV_MAX     = '1;
   localparam logic [RUN_W-1:0]  RUN_SAT    = '1;
   localparam logic [RUN_W-1:0]  LOCK_THR   = RUN_W'(LOCK_N);
   localparam logic [RUN_W-1:0]  UNLOCK_THR = RUN_W'(UNLOCK_N);

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   state_t            state_q, state_d;
   logic [2:0]        tgl_sh;
   logic              n_evt, win_end;
   logic [EVW-1:0]    ev_cnt, ev_cnt_d, ev_tot;
   logic [EVW:0]      ev_sum;
   logic              win_valid, win_valid_d;
   logic [RUN_W-1:0]  hit_run, hit_d, miss_run, miss_d;
   logic [CODE_W-1:0] code_d;
   logic              up_d, dn_d, locked_d;

   // Two sync flops plus one edge-detect flop; any toggle edge is one event.
   assign n_evt   = tgl_sh[1] ^ tgl_sh[2];
   assign win_end = (M_counter == M);
   assign ev_sum  = {1'b0, ev_cnt} + (EVW+1)'(n_evt);
   assign ev_tot  = ev_sum[EVW] ? EV_MAX : ev_sum[EVW-1:0];

   always_comb begin
      state_d     = state_q;
      code_d      = code;
      up_d        = 1'b0;
      dn_d        = 1'b0;
      locked_d    = locked;
      win_valid_d = win_valid;
      hit_d       = hit_run;
      miss_d      = miss_run;
      ev_cnt_d    = win_end ? '0 : ev_tot;
      if (!en) begin
         state_d  = IDLE;
         locked_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d     = ACQUIRE;
               win_valid_d = 1'b0;
               hit_d       = '0;
               miss_d      = '0;
            end
            ACQUIRE, LOCKED: begin
               if (win_end) begin
                  // The window in progress at entry is partial, so it only arms the compare.
                  if (!win_valid) begin
                     win_valid_d = 1'b1;
                  end else if (ev_tot == EVW'(1)) begin
                     hit_d  = (hit_run == RUN_SAT) ? hit_run : hit_run + 1'b1;
                     miss_d = '0;
                     if (state_q == ACQUIRE && hit_d >= LOCK_THR) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                     end
                  end else begin
                     hit_d  = '0;
                     miss_d = (miss_run == RUN_SAT) ? miss_run : miss_run + 1'b1;
                     if (ev_tot == '0) begin
                        if (code != '0) begin
                           code_d = code - 1'b1;
                           dn_d   = 1'b1;
                        end
                     end else if (code != CODE_MAX) begin
                        code_d = code + 1'b1;
                        up_d   = 1'b1;
                     end
                     if (state_q == LOCKED && miss_d >= UNLOCK_THR) begin
                        state_d  = ACQUIRE;
                        locked_d = 1'b0;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK_exit or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         tgl_sh    <= '0;
         ev_cnt    <= '0;
         win_valid <= 1'b0;
         hit_run   <= '0;
         miss_run  <= '0;
         code      <= CODE_RST;
         up        <= 1'b0;
         dn        <= 1'b0;
         locked    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tgl_sh    <= {tgl_sh[1:0], n_wrap_tgl};
         ev_cnt    <= ev_cnt_d;
         win_valid <= win_valid_d;
         hit_run   <= hit_d;
         miss_run  <= miss_d;
         code      <= code_d;
         up        <= up_d;
         dn        <= dn_d;
         locked    <= locked_d;
      end
   end

endmodule

// File: tb/tb_fmdll_freq_ctrl.sv
// Randomized and directed bench for fmdll_freq_ctrl against a window-level reference model.
module tb_fmdll_freq_ctrl;
   logic       CLK_exit = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0;
   logic [1:0] m_val = 2'd0;
   logic [1:0] mc = 2'd0;
   logic [1:0] M_counter = 2'd0;
   logic       n_wrap_tgl = 1'b0;
   logic [5:0] code;
   logic       up, dn, locked;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model state
   int m_code, m_mode, m_hits, m_miss, m_acc, edge_n;
   bit m_up, m_dn, m_locked, m_valid;
   int pend[$];

   fmdll_freq_ctrl dut (
      .CLK_exit(CLK_exit), .rst_n(rst_n), .en(en), .M(m_val), .M_counter(M_counter),
      .n_wrap_tgl(n_wrap_tgl), .code(code), .up(up), .dn(dn), .locked(locked)
   );

   always #5 CLK_exit = ~CLK_exit;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_code = 32; m_up = 0; m_dn = 0; m_locked = 0;
      m_mode = 0; m_valid = 0; m_hits = 0; m_miss = 0; m_acc = 0;
      pend.delete();
   endtask

   // Mode 0 idle, 1 acquire, 2 locked. A toggle driven before edge k lands at edge k+2.
   task automatic model_step();
      int arr;
      int ev;
      bit we;
      arr = 0;
      if (!rst_n) begin
         model_reset();
         return;
      end
      while (pend.size() > 0 && pend[0] <= edge_n) begin
         pend.delete(0);
         arr++;
      end
      ev = (m_acc + arr > 7) ? 7 : m_acc + arr;
      we = (mc == m_val);
      m_acc = we ? 0 : ev;
      m_up = 0; m_dn = 0;
      if (!en) begin
         m_mode = 0; m_locked = 0;
      end else if (m_mode == 0) begin
         m_mode = 1; m_valid = 0; m_hits = 0; m_miss = 0;
      end else if (we) begin
         if (!m_valid) m_valid = 1;
         else if (ev == 1) begin
            m_hits++; m_miss = 0;
            if (m_mode == 1 && m_hits >= 4) begin m_mode = 2; m_locked = 1; end
         end else begin
            m_hits = 0; m_miss++;
            if (ev == 0) begin
               if (m_code > 0) begin m_code--; m_dn = 1; end
            end else if (m_code < 63) begin
               m_code++; m_up = 1;
            end
            if (m_mode == 2 && m_miss >= 2) begin m_mode = 1; m_locked = 0; end
         end
      end
   endtask

   // Called at (or just after) a negedge; returns at the following negedge.
   task automatic cycle(input logic en_v, input logic flip);
      en = en_v;
      M_counter = mc;
      if (flip) begin
         n_wrap_tgl = ~n_wrap_tgl;
         if (rst_n) pend.push_back(edge_n + 2);
      end
      @(posedge CLK_exit);
      model_step();
      edge_n++;
      mc = (mc == m_val && m_val != 2'd0) ? 2'd0 : mc + 2'd1;
      @(negedge CLK_exit);
      chk("cyc", {23'd0, code, up, dn, locked}, {23'd0, 6'(m_code), m_up, m_dn, m_locked});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_async", {23'd0, code, up, dn, locked}, {23'd0, 6'd32, 3'b000});
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
      n_wrap_tgl = 1'b0;
      mc = 2'd0;
      rst_n = 1'b1;
   endtask

   // Runs whole windows from mc==0; tm[i] flips the toggle when mc==i.
   task automatic run_windows(input int n, input logic [3:0] tm);
      for (int w = 0; w < n; w++) begin
         cycle(1'b1, tm[mc]);
         while (mc != 2'd0) cycle(1'b1, tm[mc]);
      end
   endtask

   initial begin
      logic en_r;
      edge_n = 0;
      model_reset();
      @(negedge CLK_exit);

      // T1: reset mid-window with toggles active, then quiet outputs
      do_reset();
      m_val = 2'd3;
      run_windows(2, 4'b0101);
      cycle(1'b1, 1'b1);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1);
         chk("t1_nopulse", {30'd0, up, dn}, 32'd0);
      end

      // T2: two wraps per window -> up every valid window
      do_reset();
      m_val = 2'd3;
      run_windows(4, 4'b0101);
      chk("t2_code", code, 32'd35);
      chk("t2_lock", locked, 32'd0);

      // T3: one wrap per window, arriving on the closing edge
      do_reset();
      m_val = 2'd2;
      run_windows(4, 4'b0001);
      chk("t3_prelock", locked, 32'd0);
      run_windows(1, 4'b0001);
      chk("t3_lock", locked, 32'd1);
      chk("t3_code", code, 32'd32);

      // T4: two empty windows unlock
      run_windows(1, 4'b0000);
      chk("t4_dn", dn, 32'd1);
      chk("t4_code1", code, 32'd31);
      chk("t4_lock1", locked, 32'd1);
      run_windows(1, 4'b0000);
      chk("t4_code2", code, 32'd30);
      chk("t4_lock2", locked, 32'd0);

      // T5: M=0 natural-wrap window, drive code to the top and past it
      do_reset();
      m_val = 2'd0;
      run_windows(36, 4'b0101);
      cycle(1'b1, 1'b0);
      chk("t5_sat_code", code, 32'd63);
      chk("t5_sat_up", up, 32'd0);

      // T6: enable drop while locked, then first window after re-enable ignored
      do_reset();
      m_val = 2'd2;
      run_windows(5, 4'b0001);
      chk("t6_lock", locked, 32'd1);
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      chk("t6_unlock", locked, 32'd0);
      chk("t6_hold", code, 32'd32);
      cycle(1'b1, 1'b0);
      run_windows(1, 4'b0000);
      chk("t6_discard", code, 32'd32);
      run_windows(1, 4'b0000);
      chk("t6_step", code, 32'd31);

      // Random traffic against the model
      en_r = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         if ($urandom_range(0, 79) == 0) en_r = ~en_r;
         if ($urandom_range(0, 149) == 0) m_val = 2'($urandom_range(0, 3));
         cycle(en_r, ($urandom_range(0, 2) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
